// File: rtl/cve2_mem_arbiter_if.sv
// Bundle of the instruction, data and shared-memory ports of cve2_mem_arbiter.
// Signal names keep the arbiter-relative _i/_o suffixes of the flat port list.
interface cve2_mem_arbiter_if;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    // Arbiter side
    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    // Requester / memory environment side
    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/cve2_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one memory port, with an
// in-order ID FIFO that steers responses back to the requester that was granted.
module cve2_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cve2_mem_arbiter_if.slave   bus,
    output logic [2:0]          outstanding_o,
    output logic                protocol_err_o
);
    localparam logic       IdInstr = 1'b0;
    localparam logic       IdData  = 1'b1;
    localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
    localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

    logic       id_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] cnt_q;
    logic       lock_valid_q, lock_id_q;
    logic       prio_q;
    logic       perr_q;

    logic       win_valid, win_id, locked_req;
    logic       mem_req, grant, push, pop, head_id;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        locked_req = lock_id_q ? bus.data_req_i : bus.instr_req_i;
        win_valid  = bus.instr_req_i | bus.data_req_i;
        // A stalled winner stays selected; a lock whose owner dropped req is ignored
        if (lock_valid_q && locked_req)
            win_id = lock_id_q;
        else if (bus.instr_req_i && bus.data_req_i)
            win_id = RoundRobin ? prio_q : IdData;
        else
            win_id = bus.data_req_i;

        mem_req = rst_ni & win_valid & (cnt_q < MaxCnt);
        grant   = mem_req & bus.mem_gnt_i;
        push    = grant;
        pop     = bus.mem_rvalid_i & (cnt_q != 3'd0);
        head_id = id_q[rptr_q];
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.instr_gnt_o = grant & (win_id == IdInstr);
    assign bus.data_gnt_o  = grant & (win_id == IdData);

    always_comb begin
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (win_valid) begin
            if (win_id == IdData) begin
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end else begin
                bus.mem_be_o    = 4'hF;
                bus.mem_addr_o  = bus.instr_addr_i;
            end
        end
    end

    assign bus.instr_rvalid_o = pop & (head_id == IdInstr);
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.instr_err_o    = bus.instr_rvalid_o & bus.mem_err_i;
    assign bus.data_rvalid_o  = pop & (head_id == IdData);
    assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.data_err_o     = bus.data_rvalid_o & bus.mem_err_i;

    assign outstanding_o  = cnt_q;
    assign protocol_err_o = perr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 4; i++) id_q[i] <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            prio_q       <= IdData;
            perr_q       <= 1'b0;
        end else begin
            if (push) begin
                id_q[wptr_q] <= win_id;
                wptr_q       <= ptr_next(wptr_q);
            end
            if (pop) rptr_q <= ptr_next(rptr_q);
            cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};

            if (bus.mem_rvalid_i && cnt_q == 3'd0) perr_q <= 1'b1;

            if (mem_req && !bus.mem_gnt_i) begin
                lock_valid_q <= 1'b1;
                lock_id_q    <= win_id;
            end else if (grant || !locked_req) begin
                lock_valid_q <= 1'b0;
            end

            if (RoundRobin && grant) prio_q <= ~win_id;
        end
    end
endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Bench for cve2_mem_arbiter: two instances (fixed priority depth 2, alternating
// priority depth 4) share one stimulus; directed scenarios plus a random run vs a queue model.
module tb_cve2_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  data_be;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;

    cve2_mem_arbiter_if if_fix ();
    cve2_mem_arbiter_if if_rr ();

    assign if_fix.instr_req_i  = instr_req;
    assign if_fix.instr_addr_i = instr_addr;
    assign if_fix.data_req_i   = data_req;
    assign if_fix.data_we_i    = data_we;
    assign if_fix.data_be_i    = data_be;
    assign if_fix.data_addr_i  = data_addr;
    assign if_fix.data_wdata_i = data_wdata;
    assign if_fix.mem_gnt_i    = mem_gnt;
    assign if_fix.mem_rvalid_i = mem_rvalid;
    assign if_fix.mem_rdata_i  = mem_rdata;
    assign if_fix.mem_err_i    = mem_err;

    assign if_rr.instr_req_i   = instr_req;
    assign if_rr.instr_addr_i  = instr_addr;
    assign if_rr.data_req_i    = data_req;
    assign if_rr.data_we_i     = data_we;
    assign if_rr.data_be_i     = data_be;
    assign if_rr.data_addr_i   = data_addr;
    assign if_rr.data_wdata_i  = data_wdata;
    assign if_rr.mem_gnt_i     = mem_gnt;
    assign if_rr.mem_rvalid_i  = mem_rvalid;
    assign if_rr.mem_rdata_i   = mem_rdata;
    assign if_rr.mem_err_i     = mem_err;

    logic [2:0] out_fix, out_rr;
    logic       perr_fix, perr_rr;

    cve2_mem_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b0)) u_fix (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_fix.slave),
        .outstanding_o(out_fix), .protocol_err_o(perr_fix));

    cve2_mem_arbiter #(.MaxOutstanding(4), .RoundRobin(1'b1)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_rr.slave),
        .outstanding_o(out_rr), .protocol_err_o(perr_rr));

    int passed = 0;
    int total  = 0;

    // Reference model state, index 0 = fixed-priority instance, 1 = alternating
    bit mq [2][$];
    bit mlock_v [2];
    bit mlock_id [2];
    bit mprio [2];
    bit mperr [2];
    int mmax [2] = '{2, 4};
    bit mrr [2]  = '{1'b0, 1'b1};

    function automatic logic [143:0] act_vec(input int k);
        if (k == 0)
            return {if_fix.mem_req_o, if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_we_o,
                    if_fix.mem_be_o, if_fix.mem_addr_o, if_fix.mem_wdata_o,
                    if_fix.instr_rvalid_o, if_fix.instr_rdata_o, if_fix.instr_err_o,
                    if_fix.data_rvalid_o, if_fix.data_rdata_o, if_fix.data_err_o, out_fix, perr_fix};
        return {if_rr.mem_req_o, if_rr.instr_gnt_o, if_rr.data_gnt_o, if_rr.mem_we_o,
                if_rr.mem_be_o, if_rr.mem_addr_o, if_rr.mem_wdata_o,
                if_rr.instr_rvalid_o, if_rr.instr_rdata_o, if_rr.instr_err_o,
                if_rr.data_rvalid_o, if_rr.data_rdata_o, if_rr.data_err_o, out_rr, perr_rr};
    endfunction

    // Expected outputs for the current inputs, then advance the model by one clock
    task automatic model_cycle(input int k, output logic [143:0] v);
        int n;
        bit w, lreq, any, mreq, g, p, irv, drv;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wd;
        n    = mq[k].size();
        any  = instr_req | data_req;
        lreq = mlock_id[k] ? data_req : instr_req;
        if (mlock_v[k] && lreq)           w = mlock_id[k];
        else if (instr_req && data_req)   w = mrr[k] ? mprio[k] : 1'b1;
        else                              w = data_req;
        mreq = any && (n < mmax[k]);
        g    = mreq && mem_gnt;
        p    = mem_rvalid && (n > 0);
        irv  = p && (mq[k][0] == 1'b0);
        drv  = p && (mq[k][0] == 1'b1);
        we = 1'b0; be = 4'h0; addr = 32'h0; wd = 32'h0;
        if (any && w) begin
            we = data_we; be = data_be; addr = data_addr; wd = data_wdata;
        end else if (any) begin
            be = 4'hF; addr = instr_addr;
        end
        v = {mreq, g && !w, g && w, we, be, addr, wd,
             irv, irv ? mem_rdata : 32'h0, irv && mem_err,
             drv, drv ? mem_rdata : 32'h0, drv && mem_err, 3'(n), mperr[k]};
        if (mem_rvalid && n == 0) mperr[k] = 1'b1;
        if (p) void'(mq[k].pop_front());
        if (g) mq[k].push_back(w);
        if (mreq && !mem_gnt) begin
            mlock_v[k] = 1'b1; mlock_id[k] = w;
        end else if (g || !lreq) begin
            mlock_v[k] = 1'b0;
        end
        if (g) mprio[k] = !w;
    endtask

    task automatic idle();
        instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
        data_be = 4'h0; instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete(); mlock_v[k] = 0; mlock_id[k] = 0; mprio[k] = 1; mperr[k] = 0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
        for (int c = 0; c < 2; c++) begin
            #2;
            total++;
            if ({if_fix.mem_req_o, if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.instr_rvalid_o,
                 if_fix.data_rvalid_o, out_fix, perr_fix} !== 9'b0) begin
                $display("FAIL reset_fix[%0d]: req/gnt/rv/out/perr got %b required 0", c,
                         {if_fix.mem_req_o, if_fix.instr_gnt_o, if_fix.data_gnt_o,
                          if_fix.instr_rvalid_o, if_fix.data_rvalid_o, out_fix, perr_fix});
            end else passed++;
            total++;
            if ({if_rr.mem_req_o, if_rr.instr_gnt_o, if_rr.data_gnt_o, if_rr.instr_rvalid_o,
                 if_rr.data_rvalid_o, out_rr, perr_rr} !== 9'b0) begin
                $display("FAIL reset_rr[%0d]: req/gnt/rv/out/perr got %b required 0", c,
                         {if_rr.mem_req_o, if_rr.instr_gnt_o, if_rr.data_gnt_o,
                          if_rr.instr_rvalid_o, if_rr.data_rvalid_o, out_rr, perr_rr});
            end else passed++;
            @(posedge clk);
        end
        do_reset();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        @(negedge clk);
        instr_req = 1; data_req = 1; mem_gnt = 1; instr_addr = 32'h10; data_addr = 32'h20;
        #2; total++;
        if ({if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_addr_o} !== {2'b01, 32'h20}) begin
            $display("FAIL fixed_both: igt/dgt/addr got %b/%h required 01/00000020",
                     {if_fix.instr_gnt_o, if_fix.data_gnt_o}, if_fix.mem_addr_o);
        end else passed++;
        @(negedge clk);
        data_req = 0;
        #2; total++;
        if ({if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_addr_o, out_fix} !== {2'b10, 32'h10, 3'd1}) begin
            $display("FAIL fixed_instr_after: igt/dgt/addr/out got %b/%h/%0d required 10/00000010/1",
                     {if_fix.instr_gnt_o, if_fix.data_gnt_o}, if_fix.mem_addr_o, out_fix);
        end else passed++;
        @(negedge clk);
        instr_req = 0; mem_rvalid = 1; mem_rdata = 32'h1111;
        #2; total++;
        if ({if_fix.instr_rvalid_o, if_fix.data_rvalid_o, if_fix.data_rdata_o, out_fix} !== {2'b01, 32'h1111, 3'd2}) begin
            $display("FAIL fixed_order_head: irv/drv/drdata/out got %b/%h/%0d required 01/00001111/2",
                     {if_fix.instr_rvalid_o, if_fix.data_rvalid_o}, if_fix.data_rdata_o, out_fix);
        end else passed++;
        @(negedge clk);
        mem_rdata = 32'h2222;
        #2; total++;
        if ({if_fix.instr_rvalid_o, if_fix.data_rvalid_o, if_fix.instr_rdata_o} !== {2'b10, 32'h2222}) begin
            $display("FAIL fixed_order_tail: irv/drv/irdata got %b/%h required 10/00002222",
                     {if_fix.instr_rvalid_o, if_fix.data_rvalid_o}, if_fix.instr_rdata_o);
        end else passed++;
        @(negedge clk);
        idle();
        #2; total++;
        if (out_fix !== 3'd0) $display("FAIL fixed_drained: outstanding got %0d required 0", out_fix);
        else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        instr_req = 1; data_req = 1; mem_gnt = 1;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] exp;
            exp = (i == 4) ? {3'b000, 2'b00} : {3'(i), (i % 2 == 1), (i % 2 == 0)};
            if (i == 4) exp = {3'd4, 2'b00};
            #2; total++;
            if ({out_rr, if_rr.instr_gnt_o, if_rr.data_gnt_o} !== exp ||
                if_rr.mem_req_o !== (i < 4)) begin
                $display("FAIL rr_alternate[%0d]: out/igt/dgt/mreq got %b/%b required %b/%b", i,
                         {out_rr, if_rr.instr_gnt_o, if_rr.data_gnt_o}, if_rr.mem_req_o, exp, (i < 4));
            end else passed++;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        instr_req = 1; instr_addr = 32'h100; data_addr = 32'h200; mem_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) data_req = 1;
            #2; total++;
            if ({if_fix.mem_req_o, if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_addr_o} !== {3'b100, 32'h100}) begin
                $display("FAIL lock_hold[%0d]: mreq/igt/dgt/addr got %b/%h required 100/00000100", c,
                         {if_fix.mem_req_o, if_fix.instr_gnt_o, if_fix.data_gnt_o}, if_fix.mem_addr_o);
            end else passed++;
            @(negedge clk);
        end
        mem_gnt = 1;
        #2; total++;
        if ({if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_addr_o} !== {2'b10, 32'h100}) begin
            $display("FAIL lock_grant: igt/dgt/addr got %b/%h required 10/00000100",
                     {if_fix.instr_gnt_o, if_fix.data_gnt_o}, if_fix.mem_addr_o);
        end else passed++;
        @(negedge clk);
        instr_req = 0;
        #2; total++;
        if ({if_fix.instr_gnt_o, if_fix.data_gnt_o, if_fix.mem_addr_o} !== {2'b01, 32'h200}) begin
            $display("FAIL lock_then_data: igt/dgt/addr got %b/%h required 01/00000200",
                     {if_fix.instr_gnt_o, if_fix.data_gnt_o}, if_fix.mem_addr_o);
        end else passed++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_response_order();
        do_reset();
        @(negedge clk);
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
        @(negedge clk);
        instr_req = 0; data_req = 1; data_addr = 32'h200;
        @(negedge clk);
        data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA0000;
        #2; total++;
        if ({if_fix.instr_rvalid_o, if_fix.instr_rdata_o, if_fix.data_rvalid_o, if_fix.data_rdata_o}
            !== {1'b1, 32'hAAAA0000, 1'b0, 32'h0}) begin
            $display("FAIL resp_first: irv/ird/drv/drd got %b/%h/%b/%h required 1/aaaa0000/0/00000000",
                     if_fix.instr_rvalid_o, if_fix.instr_rdata_o, if_fix.data_rvalid_o, if_fix.data_rdata_o);
        end else passed++;
        @(negedge clk);
        mem_rdata = 32'hBBBB0000; mem_err = 1;
        #2; total++;
        if ({if_fix.instr_rvalid_o, if_fix.instr_rdata_o, if_fix.instr_err_o,
             if_fix.data_rvalid_o, if_fix.data_rdata_o, if_fix.data_err_o}
            !== {1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB0000, 1'b1}) begin
            $display("FAIL resp_second: irv/ird/ier/drv/drd/der got %b/%h/%b/%b/%h/%b required 0/0/0/1/bbbb0000/1",
                     if_fix.instr_rvalid_o, if_fix.instr_rdata_o, if_fix.instr_err_o,
                     if_fix.data_rvalid_o, if_fix.data_rdata_o, if_fix.data_err_o);
        end else passed++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk);
        data_req = 1; mem_gnt = 1;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h5;
        #2; total++;
        if ({if_fix.mem_req_o, if_fix.data_gnt_o, if_fix.data_rvalid_o, out_fix} !== {3'b001, 3'd2}) begin
            $display("FAIL full_block: mreq/dgt/drv/out got %b/%0d required 001/2",
                     {if_fix.mem_req_o, if_fix.data_gnt_o, if_fix.data_rvalid_o}, out_fix);
        end else passed++;
        @(negedge clk);
        mem_rvalid = 0;
        #2; total++;
        if ({if_fix.mem_req_o, if_fix.data_gnt_o, out_fix} !== {2'b11, 3'd1}) begin
            $display("FAIL full_slot_reuse: mreq/dgt/out got %b/%0d required 11/1",
                     {if_fix.mem_req_o, if_fix.data_gnt_o}, out_fix);
        end else passed++;
        @(negedge clk);
        data_req = 0;
        #2; total++;
        if (out_fix !== 3'd2) $display("FAIL full_refill: outstanding got %0d required 2", out_fix);
        else passed++;
        idle();
    endtask

    task automatic test_empty_rvalid();
        do_reset();
        @(negedge clk);
        instr_req = 1; mem_gnt = 1;
        @(negedge clk);
        idle();
        do_reset();
        @(negedge clk);
        mem_rvalid = 1;
        #2; total++;
        if ({if_fix.instr_rvalid_o, if_fix.data_rvalid_o, if_rr.instr_rvalid_o, if_rr.data_rvalid_o,
             perr_fix, perr_rr, out_fix} !== 9'b0) begin
            $display("FAIL empty_rvalid: rvalids/perr/out got %b required 0",
                     {if_fix.instr_rvalid_o, if_fix.data_rvalid_o, if_rr.instr_rvalid_o,
                      if_rr.data_rvalid_o, perr_fix, perr_rr, out_fix});
        end else passed++;
        @(negedge clk);
        mem_rvalid = 0;
        repeat (3) @(negedge clk);
        #2; total++;
        if ({perr_fix, perr_rr} !== 2'b11) $display("FAIL perr_sticky: got %b required 11", {perr_fix, perr_rr});
        else passed++;
        rst_n = 1'b0;
        #2; total++;
        if ({perr_fix, perr_rr} !== 2'b00) $display("FAIL perr_reset: got %b required 00", {perr_fix, perr_rr});
        else passed++;
        do_reset();
    endtask

    task automatic test_random();
        logic [143:0] e, a;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 1000 == 999) do_reset();
            @(negedge clk);
            instr_req  = ($urandom_range(0, 99) < 60);
            data_req   = ($urandom_range(0, 99) < 60);
            instr_addr = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_we    = 1'($urandom);
            data_be    = 4'($urandom);
            mem_gnt    = ($urandom_range(0, 99) < 65);
            mem_rvalid = ($urandom_range(0, 99) < ((mq[0].size() + mq[1].size()) > 0 ? 45 : 2));
            mem_rdata  = $urandom;
            mem_err    = ($urandom_range(0, 99) < 10);
            #2;
            for (int k = 0; k < 2; k++) begin
                model_cycle(k, e);
                a = act_vec(k);
                total++;
                if (a !== e) $display("FAIL random[%0d] cycle %0d: got %h required %h", k, cyc, a, e);
                else passed++;
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_response_order();
        test_full();
        test_empty_rvalid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
